// File: rtl/motor_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : motor_ramp_ctrl_if
// Brief    : Mode command and motor-driver pin bundle between the car FSM and
//            motor_ramp_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface motor_ramp_ctrl_if #(
    parameter int DUTY_W = 10
);
    logic [4:0]        mode;
    logic [1:0]        pwm;
    logic [1:0]        r_IN;
    logic [1:0]        l_IN;
    logic [DUTY_W-1:0] left_duty;
    logic [DUTY_W-1:0] right_duty;
    logic              settled;

    modport master (
        output mode,
        input  pwm, r_IN, l_IN, left_duty, right_duty, settled
    );

    modport slave (
        input  mode,
        output pwm, r_IN, l_IN, left_duty, right_duty, settled
    );
endinterface
`default_nettype wire

// File: rtl/motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motor_ramp_ctrl
// Brief    : Two-wheel duty slew controller with reversal dead-time and PWM.
//            Optional macro MOTOR_BRAKE_EN: brake (IN=11) in dead-time and
//            in zero-duty hold.
// Revision : 1.0  initial release
// ============================================================================
module motor_ramp_ctrl #(
    parameter int DUTY_W     = 10,
    parameter int FULL_SPEED = 750,
    parameter int TRIM_SPEED = 700,
    parameter int RAMP_STEP  = 25,
    parameter int RAMP_DIV   = 100000,
    parameter int DEAD_TICKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    motor_ramp_ctrl_if.slave  bus
);

    localparam int CNT_W  = $clog2(RAMP_DIV);
    localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
    localparam int CH_R   = 0;
    localparam int CH_L   = 1;

    localparam logic [DUTY_W-1:0] C_FULL      = DUTY_W'(FULL_SPEED);
    localparam logic [DUTY_W-1:0] C_TRIM      = DUTY_W'(TRIM_SPEED);
    localparam logic [DUTY_W:0]   C_STEP      = (DUTY_W+1)'(RAMP_STEP);
    localparam logic [CNT_W-1:0]  C_TICK_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] C_DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);
    localparam logic              C_FWD       = 1'b0;
    localparam logic              C_REV       = 1'b1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DECEL = 2'd1,
        S_DEAD  = 2'd2
    } ch_state_e;

    logic [CNT_W-1:0]         tick_cnt_q;
    logic                     tick;
    logic [DUTY_W-1:0]        pwm_cnt_q;
    logic [1:0][DUTY_W-1:0]   tgt_duty;
    logic [1:0]               tgt_dir;
    logic [1:0][DUTY_W-1:0]   duty_all;
    logic [1:0][1:0]          in_all;
    logic [1:0]               pwm_all;
    logic [1:0]               ok_all;
    logic                     settled_q;

    assign tick = (tick_cnt_q == C_TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            settled_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            settled_q  <= &ok_all;
        end
    end

    always_comb begin
        tgt_duty = '0;
        tgt_dir  = {C_FWD, C_FWD};
        case (bus.mode)
            5'd3, 5'd4: begin
                tgt_duty[CH_L] = C_FULL;
                tgt_duty[CH_R] = C_FULL;
            end
            5'd5: begin
                tgt_duty[CH_L] = C_FULL;
                tgt_dir[CH_L]  = C_REV;
                tgt_duty[CH_R] = C_FULL;
            end
            5'd6: begin
                tgt_duty[CH_L] = C_FULL;
                tgt_duty[CH_R] = C_FULL;
                tgt_dir[CH_R]  = C_REV;
            end
            5'd7: begin
                tgt_duty[CH_L] = C_FULL;
                tgt_duty[CH_R] = C_FULL;
                tgt_dir        = {C_REV, C_REV};
            end
            5'd8: begin
                tgt_duty[CH_L] = C_TRIM;
                tgt_duty[CH_R] = C_FULL;
            end
            5'd9: begin
                tgt_duty[CH_L] = C_FULL;
                tgt_duty[CH_R] = C_TRIM;
            end
            default: ;
        endcase
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        ch_state_e         state_q, state_d;
        logic [DUTY_W-1:0] duty_q, duty_d;
        logic              dir_q, dir_d;
        logic [DEAD_W-1:0] dead_q, dead_d;
        logic              pwm_q;
        logic [DUTY_W:0]   duty_x, tgt_x, up_x, dec_x;
        logic [DUTY_W-1:0] ramp_duty;
        logic [1:0]        dir_enc;

        // Slew arithmetic is one bit wider so the up-step cannot wrap.
        assign duty_x = {1'b0, duty_q};
        assign tgt_x  = {1'b0, tgt_duty[ch]};
        assign up_x   = duty_x + C_STEP;
        assign dec_x  = (duty_x > C_STEP) ? duty_x - C_STEP : '0;

        always_comb begin
            ramp_duty = duty_q;
            if (duty_x < tgt_x)
                ramp_duty = (up_x > tgt_x) ? tgt_duty[ch] : up_x[DUTY_W-1:0];
            else if (duty_x > tgt_x)
                ramp_duty = (dec_x < tgt_x) ? tgt_duty[ch] : dec_x[DUTY_W-1:0];
        end

        always_comb begin
            state_d = state_q;
            duty_d  = duty_q;
            dir_d   = dir_q;
            dead_d  = dead_q;
            if (tick) begin
                case (state_q)
                    S_RUN, S_DECEL: begin
                        if (tgt_dir[ch] == dir_q) begin
                            state_d = S_RUN;
                            duty_d  = ramp_duty;
                        end else begin
                            duty_d  = dec_x[DUTY_W-1:0];
                            dead_d  = '0;
                            state_d = (dec_x == '0) ? S_DEAD : S_DECEL;
                        end
                    end
                    S_DEAD: begin
                        duty_d = '0;
                        if (dead_q == C_DEAD_LAST) begin
                            dir_d   = tgt_dir[ch];
                            dead_d  = '0;
                            state_d = S_RUN;
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                    default: state_d = S_RUN;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_RUN;
                duty_q  <= '0;
                dir_q   <= C_FWD;
                dead_q  <= '0;
                pwm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                duty_q  <= duty_d;
                dir_q   <= dir_d;
                dead_q  <= dead_d;
                pwm_q   <= (pwm_cnt_q < duty_q);
            end
        end

        assign dir_enc = (dir_q == C_REV) ? 2'b01 : 2'b10;

`ifdef MOTOR_BRAKE_EN
        logic hold_q, hold_d;

        // Hold is evaluated only on ticks so mode changes release it at the next tick.
        assign hold_d = tick ? ((state_d == S_RUN) && (duty_d == '0) && (tgt_duty[ch] == '0))
                             : hold_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) hold_q <= 1'b0;
            else     hold_q <= hold_d;
        end

        assign in_all[ch] = ((state_q == S_DEAD) || hold_q) ? 2'b11 : dir_enc;
`else
        assign in_all[ch] = (state_q == S_DEAD) ? 2'b00 : dir_enc;
`endif

        assign duty_all[ch] = duty_q;
        assign pwm_all[ch]  = pwm_q;
        assign ok_all[ch]   = (state_q == S_RUN) && (duty_q == tgt_duty[ch]) &&
                              (dir_q == tgt_dir[ch]);
    end

    assign bus.pwm        = {pwm_all[CH_L], pwm_all[CH_R]};
    assign bus.l_IN       = in_all[CH_L];
    assign bus.r_IN       = in_all[CH_R];
    assign bus.left_duty  = duty_all[CH_L];
    assign bus.right_duty = duty_all[CH_R];
    assign bus.settled    = settled_q;

endmodule
`default_nettype wire
